// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA pixel-timing block (640x480@60 defaults).
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned COORD_MAX = 1 << COORD_W;
    localparam int unsigned SYNC_W    = 3;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned span_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Bit positions inside the {hs, vs, act} word carried by the delay line
    typedef enum logic [1:0] {
        SB_ACT = 2'd0,
        SB_VS  = 2'd1,
        SB_HS  = 2'd2
    } sync_bit_e;

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register carrying raw {hs, vs, act} down to the output slot.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SYNC_W-1:0] din,
    output logic [SYNC_W-1:0] tap,
    output logic [SYNC_W-1:0] dout
);

    if (DEPTH < 1) begin : g_chk_depth
        $error("vga_sync_delay: DEPTH must be at least 1");
    end

    logic [SYNC_W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // tap is the word about to enter the last stage, so a register loaded from it
    // lines up with dout on the same strobe
    if (DEPTH == 1) begin : g_tap_direct
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = stage[DEPTH-2];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: divider, h/v counters, delayed syncs and blanked colour.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned PIX_LATENCY = 2
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [COLOR_W-1:0] color_r_in,
    input  logic [COLOR_W-1:0] color_g_in,
    input  logic [COLOR_W-1:0] color_b_in,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               printting,
    output logic [COLOR_W-1:0] color_r_out,
    output logic [COLOR_W-1:0] color_g_out,
    output logic [COLOR_W-1:0] color_b_out
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_MAX) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > COORD_MAX) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL exceeds counter range");
    end
    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIX_LATENCY < 1) begin : g_chk_lat
        $error("vga_timing_gen: PIX_LATENCY must be at least 1");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EXT_W = COORD_W + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    // One spare bit so a sync window ending exactly at 1024 still compares correctly
    localparam logic [EXT_W-1:0]   H_ACT_END = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0]   HS_BEG    = EXT_W'(H_ACTIVE + H_FP);
    localparam logic [EXT_W-1:0]   HS_END    = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EXT_W-1:0]   V_ACT_END = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0]   VS_BEG    = EXT_W'(V_ACTIVE + V_FP);
    localparam logic [EXT_W-1:0]   VS_END    = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               run;
    logic [DIV_W-1:0]   div;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [EXT_W-1:0]   h_ext;
    logic [EXT_W-1:0]   v_ext;
    logic               act;
    logic               hs;
    logic               vs;
    logic [SYNC_W-1:0]  sync_raw;
    logic [SYNC_W-1:0]  sync_tap;
    logic [SYNC_W-1:0]  sync_out;

    // run keeps pix_en low during reset even when CLK_DIV=1 makes div==DIV_LAST trivially
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            run <= 1'b0;
            div <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end
        end
    end

    assign pix_en = run && (div == DIV_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};
    assign act   = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hs    = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs    = (v_ext >= VS_BEG) && (v_ext < VS_END);

    always_comb begin
        sync_raw         = '0;
        sync_raw[SB_HS]  = hs;
        sync_raw[SB_VS]  = vs;
        sync_raw[SB_ACT] = act;
    end

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign pixel_valid = act;
    assign line_start  = pix_en && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    vga_sync_delay #(
        .DEPTH (PIX_LATENCY)
    ) u_sync_delay (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .en    (pix_en),
        .din   (sync_raw),
        .tap   (sync_tap),
        .dout  (sync_out)
    );

    // Cleared delay line reads as inactive, so syncs idle high straight out of reset
    assign hsync_n   = ~sync_out[SB_HS];
    assign vsync_n   = ~sync_out[SB_VS];
    assign printting = sync_out[SB_ACT];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            color_r_out <= '0;
            color_g_out <= '0;
            color_b_out <= '0;
        end else if (pix_en) begin
            color_r_out <= sync_tap[SB_ACT] ? color_r_in : '0;
            color_g_out <= sync_tap[SB_ACT] ? color_g_in : '0;
            color_b_out <= sync_tap[SB_ACT] ? color_b_in : '0;
        end
    end

endmodule
